// File: rtl/audio_codec_sequencer_pkg.sv
// Shared definitions for the WM8731 init/loopback sequencer: register map,
// status bits, FSM states and the fixed codec init table.
package audio_codec_sequencer_pkg;

  localparam logic [2:0] ADDR_STATUS_AUDIO   = 3'd0;
  localparam logic [2:0] ADDR_I2C_DATA_AUDIO = 3'd1;
  localparam logic [2:0] ADDR_DAC_AUDIO      = 3'd2;
  localparam logic [2:0] ADDR_ADC_AUDIO      = 3'd3;

  localparam int STAT_I2C_BUSY  = 0;
  localparam int STAT_DAC_FULL  = 1;
  localparam int STAT_ADC_FULL  = 2;
  localparam int STAT_ADC_EMPTY = 3;

  localparam logic [7:0] I2C_DEV_ADDR = 8'h34;

  typedef enum logic [2:0] {
    S_IDLE,
    S_I_RD,
    S_I_WR,
    S_I_POLL,
    S_R_STAT,
    S_R_ADC,
    S_R_DAC,
    S_ERROR
  } state_e;

  // Packet layout is {device address, reg[6:0], data[8:0]}.
  function automatic logic [23:0] init_packet(input logic [3:0] idx);
    logic [15:0] body;
    case (idx)
      4'd0:    body = 16'h1E00;
      4'd1:    body = 16'h0017;
      4'd2:    body = 16'h0217;
      4'd3:    body = 16'h0479;
      4'd4:    body = 16'h0679;
      4'd5:    body = 16'h0812;
      4'd6:    body = 16'h0A00;
      4'd7:    body = 16'h0C00;
      4'd8:    body = 16'h0E42;
      4'd9:    body = 16'h1201;
      default: body = 16'h0000;
    endcase
    return {I2C_DEV_ADDR, body};
  endfunction

endpackage

// File: rtl/audio_codec_sequencer_xfer.sv
// Single Avalon-style transfer engine: turns a request into one registered
// strobe cycle (stretched by waitrequest) and reports completion.
module avalon_single_xfer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        read_o,
  output logic        write_o,
  output logic        chipselect_o,
  output logic [2:0]  address_o,
  output logic [31:0] writedata_o,
  input  logic [31:0] readdata_i,
  input  logic        waitrequest_i
);

  // Handshake: req_i is only accepted while no transfer is active, so the
  // requester may hold it level. done_o is high in the cycle whose closing
  // edge completes the transfer; rdata_o is valid in that same cycle and the
  // requester captures it on that edge.
  logic        read_q, write_q, cs_q;
  logic [2:0]  addr_q;
  logic [31:0] wdata_q;
  logic        active;

  assign active = cs_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      cs_q    <= 1'b0;
      addr_q  <= 3'd0;
      wdata_q <= 32'd0;
    end else if (!active) begin
      if (req_i) begin
        read_q  <= ~we_i;
        write_q <= we_i;
        cs_q    <= 1'b1;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end else if (!waitrequest_i) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      cs_q    <= 1'b0;
      addr_q  <= 3'd0;
      wdata_q <= 32'd0;
    end
  end

  assign done_o       = active & ~waitrequest_i;
  assign rdata_o      = readdata_i;
  assign read_o       = read_q;
  assign write_o      = write_q;
  assign chipselect_o = cs_q;
  assign address_o    = addr_q;
  assign writedata_o  = wdata_q;

endmodule

// File: rtl/audio_codec_sequencer.sv
// Configures the WM8731 through the audio controller slave from a fixed init
// table, then streams ADC samples to the DAC while loopback is enabled.
module audio_codec_sequencer
  import audio_codec_sequencer_pkg::*;
#(
  parameter int INIT_LEN = 10,
  parameter int POLL_MAX = 1024
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        start,
  input  logic        loopback_en,
  output logic        init_done,
  output logic        busy,
  output logic        error,
  output logic [15:0] sample_count,
  output logic        master_read,
  output logic        master_write,
  output logic        master_chipselect,
  output logic [2:0]  master_address,
  output logic [31:0] master_writedata,
  input  logic [31:0] master_readdata,
  input  logic        master_waitrequest,
  output state_e      dbg_state_o
);

  localparam int IDX_W  = $clog2(INIT_LEN);
  localparam int PCNT_W = $clog2(POLL_MAX + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PCNT_W-1:0]   poll_q, poll_d;
  logic                init_done_q, init_done_d;
  logic [15:0]         smp_cnt_q, smp_cnt_d;
  logic [31:0]         i2c_rd_q, i2c_rd_d;
  logic [31:0]         sample_q, sample_d;

  logic        req, we, done;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      poll_q      <= '0;
      init_done_q <= 1'b0;
      smp_cnt_q   <= 16'd0;
      i2c_rd_q    <= 32'd0;
      sample_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      poll_q      <= poll_d;
      init_done_q <= init_done_d;
      smp_cnt_q   <= smp_cnt_d;
      i2c_rd_q    <= i2c_rd_d;
      sample_q    <= sample_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    poll_d      = poll_q;
    init_done_d = init_done_q;
    smp_cnt_d   = smp_cnt_q;
    i2c_rd_d    = i2c_rd_q;
    sample_d    = sample_q;
    req         = 1'b0;
    we          = 1'b0;
    addr        = ADDR_STATUS_AUDIO;
    wdata       = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d       = '0;
          poll_d      = '0;
          init_done_d = 1'b0;
          state_d     = S_I_RD;
        end
      end
      S_I_RD: begin
        req  = 1'b1;
        addr = ADDR_I2C_DATA_AUDIO;
        if (done) begin
          i2c_rd_d = rdata;
          state_d  = S_I_WR;
        end
      end
      S_I_WR: begin
        // Top byte of the I2C data register belongs to the controller; keep it.
        req   = 1'b1;
        we    = 1'b1;
        addr  = ADDR_I2C_DATA_AUDIO;
        wdata = (i2c_rd_q & 32'hFF000000) | {8'h00, init_packet(4'(idx_q))};
        if (done) begin
          poll_d  = '0;
          state_d = S_I_POLL;
        end
      end
      S_I_POLL: begin
        req  = 1'b1;
        addr = ADDR_STATUS_AUDIO;
        if (done) begin
          if (!rdata[STAT_I2C_BUSY]) begin
            if (idx_q == IDX_W'(INIT_LEN - 1)) begin
              init_done_d = 1'b1;
              state_d     = S_R_STAT;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_I_RD;
            end
          end else if (poll_q == PCNT_W'(POLL_MAX - 1)) begin
            state_d = S_ERROR;
          end else begin
            poll_d = poll_q + PCNT_W'(1);
          end
        end
      end
      S_R_STAT: begin
        // A status read already on the bus completes even if loopback drops.
        req  = loopback_en;
        addr = ADDR_STATUS_AUDIO;
        if (done && !rdata[STAT_ADC_EMPTY] && !rdata[STAT_DAC_FULL]) begin
          state_d = S_R_ADC;
        end
      end
      S_R_ADC: begin
        req  = 1'b1;
        addr = ADDR_ADC_AUDIO;
        if (done) begin
          sample_d = rdata;
          state_d  = S_R_DAC;
        end
      end
      S_R_DAC: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = ADDR_DAC_AUDIO;
        wdata = sample_q;
        if (done) begin
          smp_cnt_d = smp_cnt_q + 16'd1;
          state_d   = S_R_STAT;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  avalon_single_xfer u_xfer (
    .clk_i        (Clk),
    .rst_ni       (Rst_n),
    .req_i        (req),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .done_o       (done),
    .rdata_o      (rdata),
    .read_o       (master_read),
    .write_o      (master_write),
    .chipselect_o (master_chipselect),
    .address_o    (master_address),
    .writedata_o  (master_writedata),
    .readdata_i   (master_readdata),
    .waitrequest_i(master_waitrequest)
  );

  assign init_done    = init_done_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign error        = (state_q == S_ERROR);
  assign sample_count = smp_cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_audio_codec_sequencer.sv
// Directed bench for audio_codec_sequencer with a behavioural slave and a
// write scoreboard fed from the stimulus thread.
module tb_audio_codec_sequencer;
  import audio_codec_sequencer_pkg::*;

  logic        Clk, Rst_n, start, loopback_en;
  logic        init_done, busy, error;
  logic [15:0] sample_count;
  logic        master_read, master_write, master_chipselect;
  logic [2:0]  master_address;
  logic [31:0] master_writedata, master_readdata;
  logic        master_waitrequest;
  state_e      dbg_state;

  logic [31:0] status_val, i2c_val, adc_val;
  logic [34:0] exp_q[$];
  logic [23:0] pkt_tab [10];

  int checks = 0;
  int errors = 0;
  int wr_done_cnt = 0;
  int stat_rd_cnt = 0;
  int adc_rd_cnt = 0;

  audio_codec_sequencer dut (
    .Clk               (Clk),
    .Rst_n             (Rst_n),
    .start             (start),
    .loopback_en       (loopback_en),
    .init_done         (init_done),
    .busy              (busy),
    .error             (error),
    .sample_count      (sample_count),
    .master_read       (master_read),
    .master_write      (master_write),
    .master_chipselect (master_chipselect),
    .master_address    (master_address),
    .master_writedata  (master_writedata),
    .master_readdata   (master_readdata),
    .master_waitrequest(master_waitrequest),
    .dbg_state_o       (dbg_state)
  );

  // clock / slave model
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign master_readdata = (master_address == 3'd0) ? status_val :
                           (master_address == 3'd1) ? i2c_val :
                           (master_address == 3'd3) ? adc_val : 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: inputs only change at posedge+1, so a strobe seen at
  // the negedge with waitrequest low completes on the following edge
  always @(negedge Clk) begin
    if (Rst_n && master_chipselect) begin
      check("rw_exclusive", 64'(master_read & master_write), 64'd0);
      if (!master_waitrequest) begin
        if (master_write) begin
          wr_done_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none",
                     master_address, master_writedata);
          end else begin
            logic [34:0] e;
            e = exp_q.pop_front();
            check("bus_write", 64'({master_address, master_writedata}), 64'(e));
          end
        end else if (master_read) begin
          if (master_address == 3'd0) stat_rd_cnt++;
          if (master_address == 3'd3) adc_rd_cnt++;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    start = 1'b0;
    loopback_en = 1'b0;
    master_waitrequest = 1'b0;
    repeat (2) tick();
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_init(input logic [31:0] top);
    for (int i = 0; i < 10; i++)
      exp_q.push_back({3'd1, (top & 32'hFF000000) | {8'h00, pkt_tab[i]}});
  endtask

  task automatic wait_init(input int max_cyc, output int n);
    n = 0;
    while (n < max_cyc) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
      if (init_done) break;
    end
    #1;
  endtask

  task automatic wait_strobe(input logic wr, input logic [2:0] a, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if ((wr ? master_write : master_read) && master_address == a) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base_wr, base_adc, base_stat;
    logic [2:0]  hold_a;
    logic [31:0] hold_d;

    pkt_tab = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                24'h340812, 24'h340A00, 24'h340C00, 24'h340E42, 24'h341201};
    status_val = 32'd0;
    i2c_val = 32'd0;
    adc_val = 32'd0;
    Rst_n = 1'b0;
    start = 1'b0;
    loopback_en = 1'b0;
    master_waitrequest = 1'b0;

    // reset values
    repeat (2) tick();
    check("rst_strobes", 64'({master_read, master_write, master_chipselect}), 64'd0);
    check("rst_addr_data", 64'({master_address, master_writedata}), 64'd0);
    check("rst_flags", 64'({init_done, busy, error}), 64'd0);
    check("rst_sample_count", 64'(sample_count), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    Rst_n = 1'b1;
    tick();

    // zero-wait init, status always 0
    push_init(32'd0);
    pulse_start();
    wait_init(200, n);
    check("init_latency", 64'(n), 64'd60);
    check("init_done", 64'(init_done), 64'd1);
    repeat (3) tick();
    check("init_writes_consumed", 64'(exp_q.size()), 64'd0);

    // start outside IDLE is ignored, R_STAT idles without loopback
    base_wr = wr_done_cnt;
    base_stat = stat_rd_cnt;
    pulse_start();
    repeat (10) tick();
    check("start_ignored_state", 64'(dbg_state), 64'(S_R_STAT));
    check("start_ignored_done", 64'(init_done), 64'd1);
    check("rstat_no_bus", 64'(stat_rd_cnt - base_stat + wr_done_cnt - base_wr), 64'd0);

    // one loopback sample, loopback dropped mid-pair
    adc_val = 32'h12345678;
    exp_q.push_back({3'd2, 32'h12345678});
    loopback_en = 1'b1;
    wait_strobe(1'b0, 3'd3, "adc_read_seen_1");
    loopback_en = 1'b0;
    repeat (20) tick();
    check("sample_count_1", 64'(sample_count), 64'd1);
    check("dac_write_1_done", 64'(exp_q.size()), 64'd0);
    check("busy_in_rstat", 64'(busy), 64'd1);

    // DAC full blocks the ADC read until it clears
    status_val = 32'h2;
    adc_val = 32'hCAFEF00D;
    base_adc = adc_rd_cnt;
    base_stat = stat_rd_cnt;
    loopback_en = 1'b1;
    repeat (30) tick();
    check("dac_full_no_adc", 64'(adc_rd_cnt - base_adc), 64'd0);
    check("dac_full_repolls", 64'(stat_rd_cnt - base_stat > 5), 64'd1);
    exp_q.push_back({3'd2, 32'hCAFEF00D});
    status_val = 32'd0;
    wait_strobe(1'b0, 3'd3, "adc_read_seen_2");
    loopback_en = 1'b0;
    repeat (20) tick();
    check("sample_count_2", 64'(sample_count), 64'd2);
    check("adc_reads_2", 64'(adc_rd_cnt - base_adc), 64'd1);
    check("dac_write_2_done", 64'(exp_q.size()), 64'd0);

    // reset in the middle of an ADC read
    loopback_en = 1'b1;
    wait_strobe(1'b0, 3'd3, "adc_read_seen_3");
    Rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", 64'({master_read, master_write, master_chipselect}), 64'd0);
    loopback_en = 1'b0;
    tick();
    Rst_n = 1'b1;
    tick();
    check("rst_mid_state", 64'(dbg_state), 64'(S_IDLE));
    check("rst_mid_sample_count", 64'(sample_count), 64'd0);
    check("rst_mid_init_done", 64'(init_done), 64'd0);

    // preserved top byte, with a 3-cycle stall on the first write
    i2c_val = 32'hA5000000;
    push_init(32'hA5000000);
    pulse_start();
    wait_strobe(1'b1, 3'd1, "first_write_seen");
    master_waitrequest = 1'b1;
    hold_a = master_address;
    hold_d = master_writedata;
    base_wr = wr_done_cnt;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_write_held", 64'({master_write, master_address, master_writedata}),
            64'({1'b1, hold_a, hold_d}));
    end
    master_waitrequest = 1'b0;
    tick();
    check("stall_strobe_drop", 64'(master_write), 64'd0);
    check("stall_one_completion", 64'(wr_done_cnt - base_wr), 64'd1);
    wait_init(400, n);
    check("init_done_a5", 64'(init_done), 64'd1);
    repeat (3) tick();
    check("a5_writes_consumed", 64'(exp_q.size()), 64'd0);

    // I2C busy stuck high -> timeout after 1024 polls
    do_reset();
    i2c_val = 32'd0;
    status_val = 32'h1;
    exp_q.push_back({3'd1, 32'h00341E00});
    stat_rd_cnt = 0;
    pulse_start();
    n = 0;
    while (!error && n < 5000) begin
      tick();
      n++;
    end
    check("poll_error", 64'(error), 64'd1);
    check("poll_count", 64'(stat_rd_cnt), 64'd1024);
    tick();
    check("error_busy", 64'(busy), 64'd0);
    check("error_bus_idle", 64'({master_read, master_write, master_chipselect}), 64'd0);
    pulse_start();
    repeat (5) tick();
    check("error_sticky", 64'({error, init_done}), 64'({1'b1, 1'b0}));
    check("error_state", 64'(dbg_state), 64'(S_ERROR));
    check("error_writes_consumed", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
